// File: rtl/modulo_n_counter_tff_en.sv
// Enabled toggle flop: q inverts on each rising edge where toggle is high.
// Latency: one edge from toggle to q; asynchronous active-low clear.
// No backpressure: toggle is acted on every edge it is high.
module tff_en (
  input  logic clk,
  input  logic rstN,
  input  logic toggle,
  output logic q
);

  // Hold or invert the stored bit; clear immediately when rstN drops.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      q <= 1'b0;
    end else if (toggle) begin
      q <= ~q;
    end
  end

endmodule

// File: rtl/modulo_n_counter.sv
// Modulo-N up/down counter with enable, clamped parallel load, wrap pulse and divide-by-2N toggle.
// Latency: count, wrap and out all update on the same rising edge; no combinational input-to-output path.
// No backpressure: steps on every enabled edge; load overrides enable.
module modulo_n_counter #(
  parameter int WIDTH   = 3,
  parameter int MODULUS = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             wrap,
  output logic             out
);

  // Counts live in 0..MODULUS-1, so MODULUS itself needs WIDTH+1 bits when it equals 2**WIDTH.
  localparam logic [WIDTH:0]   MOD_EXT  = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH:0]   TERM_EXT = (WIDTH+1)'(MODULUS - 1);
  localparam logic [WIDTH:0]   ONE_EXT  = (WIDTH+1)'(1);
  localparam logic [WIDTH-1:0] TERM     = WIDTH'(MODULUS - 1);

  generate
    if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : gBadModulus
      $error("modulo_n_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
    end
  endgenerate

  logic [WIDTH:0]   countExt;
  logic [WIDTH:0]   loadExt;
  logic [WIDTH-1:0] countNext;
  logic             wrapEdge;

  assign countExt = {1'b0, count};
  assign loadExt  = {1'b0, load_val};

  // Next count and wrap detection: load beats enable; wrap found by terminal compare, not carry-out.
  always_comb begin
    countNext = count;
    wrapEdge  = 1'b0;
    if (load) begin
      countNext = (loadExt < MOD_EXT) ? load_val : TERM;
    end else if (en) begin
      if (up_dn) begin
        if (countExt == TERM_EXT) begin
          countNext = '0;
          wrapEdge  = 1'b1;
        end else begin
          countNext = WIDTH'(countExt + ONE_EXT);
        end
      end else begin
        if (countExt == '0) begin
          countNext = TERM;
          wrapEdge  = 1'b1;
        end else begin
          countNext = WIDTH'(countExt - ONE_EXT);
        end
      end
    end
  end

  // Count register and one-cycle wrap pulse; reset clears both without producing a pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
      wrap  <= 1'b0;
    end else begin
      count <= countNext;
      wrap  <= wrapEdge;
    end
  end

  tff_en uOutTff (
    .clk    (clk),
    .rstN   (reset),
    .toggle (wrapEdge),
    .q      (out)
  );

endmodule

// File: tb/tb_modulo_n_counter.sv
// Bench for modulo_n_counter at (3,6), (4,16) and (4,10) against a modular-arithmetic reference model.
// Latency: checks 1 time unit after each rising edge; async reset checked between edges.
// No backpressure: inputs driven every cycle.
module tb_modulo_n_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstN;
  logic enA, upA, ldA;  logic [2:0] lvA;  logic [2:0] cntA;  logic wrapA, outA;
  logic enB, upB, ldB;  logic [3:0] lvB;  logic [3:0] cntB;  logic wrapB, outB;
  logic enC, upC, ldC;  logic [3:0] lvC;  logic [3:0] cntC;  logic wrapC, outC;

  modulo_n_counter #(.WIDTH(3), .MODULUS(6)) dutA (
    .clk(clk), .reset(rstN), .en(enA), .up_dn(upA), .load(ldA), .load_val(lvA),
    .count(cntA), .wrap(wrapA), .out(outA));
  modulo_n_counter #(.WIDTH(4), .MODULUS(16)) dutB (
    .clk(clk), .reset(rstN), .en(enB), .up_dn(upB), .load(ldB), .load_val(lvB),
    .count(cntB), .wrap(wrapB), .out(outB));
  modulo_n_counter #(.WIDTH(4), .MODULUS(10)) dutC (
    .clk(clk), .reset(rstN), .en(enC), .up_dn(upC), .load(ldC), .load_val(lvC),
    .count(cntC), .wrap(wrapC), .out(outC));

  int nCmp = 0;
  int nErr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: one slot per DUT, plain modular arithmetic.
  int mods[3] = '{6, 16, 10};
  int mc[3];
  int mw[3];
  int mo[3];

  task automatic modelReset();
    for (int k = 0; k < 3; k++) begin
      mc[k] = 0; mw[k] = 0; mo[k] = 0;
    end
  endtask

  task automatic modelStep(input int k, input bit ld, input int lv, input bit e, input bit u);
    int m;
    bit w;
    m = mods[k];
    if (ld) begin
      mc[k] = (lv < m) ? lv : m - 1;
      mw[k] = 0;
    end else if (e) begin
      w = u ? (mc[k] == m - 1) : (mc[k] == 0);
      mc[k] = (mc[k] + (u ? 1 : m - 1)) % m;
      mw[k] = w ? 1 : 0;
      if (w) mo[k] = 1 - mo[k];
    end else begin
      mw[k] = 0;
    end
  endtask

  task automatic checkAll();
    chk("A_count", 32'(cntA), 32'(mc[0])); chk("A_wrap", 32'(wrapA), 32'(mw[0])); chk("A_out", 32'(outA), 32'(mo[0]));
    chk("B_count", 32'(cntB), 32'(mc[1])); chk("B_wrap", 32'(wrapB), 32'(mw[1])); chk("B_out", 32'(outB), 32'(mo[1]));
    chk("C_count", 32'(cntC), 32'(mc[2])); chk("C_wrap", 32'(wrapC), 32'(mw[2])); chk("C_out", 32'(outC), 32'(mo[2]));
  endtask

  task automatic stepAll();
    @(posedge clk);
    modelStep(0, ldA, int'(lvA), enA, upA);
    modelStep(1, ldB, int'(lvB), enB, upB);
    modelStep(2, ldC, int'(lvC), enC, upC);
    #1;
    checkAll();
  endtask

  task automatic idleAll();
    enA = 0; upA = 1; ldA = 0; lvA = '0;
    enB = 0; upB = 1; ldB = 0; lvB = '0;
    enC = 0; upC = 1; ldC = 0; lvC = '0;
  endtask

  typedef struct {
    bit ld; int lv; bit en; bit up;
    int eCount; bit eWrap; bit eOut;
  } vec_t;

  vec_t tbl[23];

  int wraps;
  int maxC;

  initial begin
    // Directed table for the mod-6 instance, starting from reset (count 0, out 0).
    tbl[0]  = '{0, 0, 1, 1, 1, 0, 0};
    tbl[1]  = '{0, 0, 1, 1, 2, 0, 0};
    tbl[2]  = '{0, 0, 1, 1, 3, 0, 0};
    tbl[3]  = '{0, 0, 1, 1, 4, 0, 0};
    tbl[4]  = '{0, 0, 1, 1, 5, 0, 0};
    tbl[5]  = '{0, 0, 1, 1, 0, 1, 1};   // 5 -> 0 wrap
    tbl[6]  = '{0, 0, 1, 1, 1, 0, 1};
    tbl[7]  = '{0, 0, 1, 1, 2, 0, 1};
    tbl[8]  = '{0, 0, 1, 0, 1, 0, 1};   // direction flips down
    tbl[9]  = '{0, 0, 1, 0, 0, 0, 1};
    tbl[10] = '{0, 0, 1, 0, 5, 1, 0};   // 0 -> 5 wrap
    tbl[11] = '{0, 0, 1, 0, 4, 0, 0};
    tbl[12] = '{1, 7, 0, 1, 5, 0, 0};   // out-of-range load clamps
    tbl[13] = '{1, 3, 1, 1, 3, 0, 0};   // load wins over en
    tbl[14] = '{0, 0, 1, 1, 4, 0, 0};
    tbl[15] = '{0, 0, 1, 1, 5, 0, 0};
    tbl[16] = '{0, 0, 0, 1, 5, 0, 0};
    tbl[17] = '{0, 0, 0, 1, 5, 0, 0};
    tbl[18] = '{0, 0, 1, 1, 0, 1, 1};
    tbl[19] = '{0, 0, 0, 1, 0, 0, 1};   // hold clears wrap
    tbl[20] = '{1, 5, 0, 1, 5, 0, 1};
    tbl[21] = '{0, 0, 1, 1, 0, 1, 0};
    tbl[22] = '{1, 2, 1, 1, 2, 0, 0};   // load right after wrap

    idleAll();
    rstN = 1'b0;
    modelReset();
    #12;
    checkAll();
    @(negedge clk);
    rstN = 1'b1;

    for (int i = 0; i < 23; i++) begin
      ldA = tbl[i].ld; lvA = 3'(tbl[i].lv); enA = tbl[i].en; upA = tbl[i].up;
      stepAll();
      chk($sformatf("tbl%0d_count", i), 32'(cntA), 32'(tbl[i].eCount));
      chk($sformatf("tbl%0d_wrap", i), 32'(wrapA), 32'(tbl[i].eWrap));
      chk($sformatf("tbl%0d_out", i), 32'(outA), 32'(tbl[i].eOut));
    end

    // From count 2, eight up steps reach count 4 with out high, then reset lands between edges.
    idleAll();
    enA = 1; upA = 1;
    for (int i = 0; i < 8; i++) stepAll();
    chk("pre_rst_count", 32'(cntA), 32'd4);
    chk("pre_rst_out", 32'(outA), 32'd1);
    #2;
    rstN = 1'b0;
    #1;
    chk("async_rst_count", 32'(cntA), 32'd0);
    chk("async_rst_out", 32'(outA), 32'd0);
    chk("async_rst_wrap", 32'(wrapA), 32'd0);
    modelReset();
    @(negedge clk);
    rstN = 1'b1;
    stepAll();
    chk("post_rst_count", 32'(cntA), 32'd1);
    chk("post_rst_wrap", 32'(wrapA), 32'd0);

    // Full-range modulus: 33 up steps from 0 give exactly two wraps.
    idleAll();
    enB = 1; upB = 1;
    wraps = 0;
    for (int i = 0; i < 33; i++) begin
      stepAll();
      if (wrapB) wraps++;
    end
    chk("B16_wraps", 32'(wraps), 32'd2);
    chk("B16_count", 32'(cntB), 32'd1);
    chk("B16_out", 32'(outB), 32'd0);

    // Mod-10 in a 4-bit register: never passes 9.
    idleAll();
    enC = 1; upC = 1;
    maxC = 0;
    for (int i = 0; i < 25; i++) begin
      stepAll();
      if (int'(cntC) > maxC) maxC = int'(cntC);
    end
    chk("C10_max", 32'(maxC), 32'd9);
    chk("C10_count", 32'(cntC), 32'd5);

    // Random traffic on all three instances against the model.
    for (int i = 0; i < 600; i++) begin
      ldA = ($urandom_range(0, 7) == 0); lvA = 3'($urandom); enA = ($urandom_range(0, 3) != 0); upA = 1'($urandom);
      ldB = ($urandom_range(0, 7) == 0); lvB = 4'($urandom); enB = ($urandom_range(0, 3) != 0); upB = 1'($urandom);
      ldC = ($urandom_range(0, 7) == 0); lvC = 4'($urandom); enC = ($urandom_range(0, 3) != 0); upC = 1'($urandom);
      stepAll();
      if (int'(cntC) > maxC) maxC = int'(cntC);
    end
    chk("C10_max_rand", 32'(maxC), 32'd9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
